// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Contents:
//   alu_op_t       5-bit opcode encoding
//   alu_state_t    handshake FSM states
//   is_multicycle  true for opcodes that run on the iterative engine
// Build option: ALU_DIV_EN (when undefined, DIV is not multi-cycle and decodes as illegal).
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_SHR  = 5'b00101,
        OP_SHRA = 5'b00110,
        OP_SHL  = 5'b00111,
        OP_ROR  = 5'b01000,
        OP_ROL  = 5'b01001,
        OP_AND  = 5'b01010,
        OP_OR   = 5'b01011,
        OP_MUL  = 5'b01111,
        OP_DIV  = 5'b10000,
        OP_NEG  = 5'b10001,
        OP_NOT  = 5'b10010
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_ITER = 2'b10,
        ST_FIX  = 2'b11
    } alu_state_t;

    function automatic logic is_multicycle(input logic [4:0] op);
        case (op)
            OP_MUL:  return 1'b1;
`ifdef ALU_DIV_EN
            OP_DIV:  return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle of the sequential ALU.
//   master: start, operation, A, B driven; busy, done, zhi, zlo, err observed
//   slave : the ALU side
interface seq_alu_if #(parameter int WIDTH = 32);
    logic             start;
    logic [4:0]       operation;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] zhi;
    logic [WIDTH-1:0] zlo;
    logic             err;

    modport master (output start, operation, A, B, input busy, done, zhi, zlo, err);
    modport slave  (input start, operation, A, B, output busy, done, zhi, zlo, err);
endinterface

// File: rtl/seq_muldiv.sv
// Shared iterative engine: signed radix-2 Booth multiply and restoring
// divide on magnitudes, one step per cycle for WIDTH steps.
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   load_i             initialise from a_i/b_i in the selected mode
//   step_i             perform one iteration (counter WIDTH-1 down to 0)
//   div_i              mode select at load: 1 = divide, 0 = multiply
//   a_i, b_i           operands (a_i must stay stable until the result is taken)
//   last_o             the current step is the final one
//   hi_o, lo_o, err_o  result after the current step, sign-fixed, valid with last_o & step_i
// Build option: ALU_DIV_EN (divider datapath only present when defined).
module seq_muldiv #(parameter int WIDTH = 32) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             err_o
);
    localparam int CW = $clog2(WIDTH);

    // One guard bit on the accumulator so Booth's A-M and the divider's trial subtract never overflow.
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] sr_q;
    logic             qm1_q;
    logic [WIDTH:0]   m_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   acc_n_s;
    logic [WIDTH-1:0] sr_n_s;
    logic             qm1_n_s;
    logic [WIDTH-1:0] ld_sr_s;
    logic [WIDTH:0]   ld_m_s;

    // Booth add/subtract selected by the multiplier bit pair
    always_comb begin
        case ({sr_q[0], qm1_q})
            2'b01:   mul_sum_s = acc_q + m_q;
            2'b10:   mul_sum_s = acc_q - m_q;
            default: mul_sum_s = acc_q;
        endcase
    end

`ifdef ALU_DIV_EN
    logic             div_q;
    logic             negq_q;
    logic             negr_q;
    logic             dz_q;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_trial_s;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    // Restoring-division trial subtract of the shifted partial remainder
    always_comb begin
        div_shift_s = {acc_q[WIDTH-1:0], sr_q[WIDTH-1]};
        div_trial_s = div_shift_s - m_q;
    end

    // Next iteration state for the active mode
    always_comb begin
        if (div_q) begin
            qm1_n_s = qm1_q;
            if (!div_trial_s[WIDTH]) begin
                acc_n_s = div_trial_s;
                sr_n_s  = {sr_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n_s = div_shift_s;
                sr_n_s  = {sr_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_n_s = {mul_sum_s[WIDTH], mul_sum_s[WIDTH:1]};
            sr_n_s  = {mul_sum_s[0], sr_q[WIDTH-1:1]};
            qm1_n_s = sr_q[0];
        end
    end

    // Load values: divider works on magnitudes, multiplier on the signed operands
    always_comb begin
        if (div_i) begin
            ld_sr_s = mag(a_i);
            ld_m_s  = {1'b0, mag(b_i)};
        end else begin
            ld_sr_s = a_i;
            ld_m_s  = {b_i[WIDTH-1], b_i};
        end
    end

    // Sign fixup applied to the final step: quotient toward zero, remainder follows A
    always_comb begin
        hi_o  = acc_n_s[WIDTH-1:0];
        lo_o  = sr_n_s;
        err_o = 1'b0;
        if (div_q) begin
            if (dz_q) begin
                hi_o  = a_i;
                lo_o  = {WIDTH{1'b1}};
                err_o = 1'b1;
            end else begin
                lo_o = negq_q ? ({WIDTH{1'b0}} - sr_n_s) : sr_n_s;
                hi_o = negr_q ? ({WIDTH{1'b0}} - acc_n_s[WIDTH-1:0]) : acc_n_s[WIDTH-1:0];
            end
        end else begin
            err_o = 1'b0;
        end
    end

    // Divide mode and sign flags captured at load
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q  <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            dz_q   <= 1'b0;
        end else if (load_i) begin
            div_q  <= div_i;
            negq_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
            negr_q <= a_i[WIDTH-1];
            dz_q   <= (b_i == {WIDTH{1'b0}});
        end
    end
`else
    logic unused_div_s;
    assign unused_div_s = div_i;

    // Next iteration state: multiply only
    always_comb begin
        acc_n_s = {mul_sum_s[WIDTH], mul_sum_s[WIDTH:1]};
        sr_n_s  = {mul_sum_s[0], sr_q[WIDTH-1:1]};
        qm1_n_s = sr_q[0];
        ld_sr_s = a_i;
        ld_m_s  = {b_i[WIDTH-1], b_i};
        hi_o    = acc_n_s[WIDTH-1:0];
        lo_o    = sr_n_s;
        err_o   = 1'b0;
    end
`endif

    assign last_o = (cnt_q == {CW{1'b0}});

    // Iteration registers and step counter
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= {(WIDTH+1){1'b0}};
            sr_q  <= {WIDTH{1'b0}};
            qm1_q <= 1'b0;
            m_q   <= {(WIDTH+1){1'b0}};
            cnt_q <= {CW{1'b0}};
        end else if (load_i) begin
            acc_q <= {(WIDTH+1){1'b0}};
            sr_q  <= ld_sr_s;
            qm1_q <= 1'b0;
            m_q   <= ld_m_s;
            cnt_q <= CW'(WIDTH - 1);
        end else if (step_i) begin
            acc_q <= acc_n_s;
            sr_q  <= sr_n_s;
            qm1_q <= qm1_n_s;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU top: start/done handshake FSM, operand registers and the
// single-cycle result mux; MUL/DIV run on seq_muldiv.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   bus (slave)   start/operation/A/B in; busy/done/zhi/zlo/err out (all registered)
// Build option: ALU_DIV_EN enables the DIV opcode; otherwise DIV is illegal.
module seq_alu #(parameter int WIDTH = 32) (
    input  logic       clock,
    input  logic       reset,
    seq_alu_if.slave   bus
);
    import alu_pkg::*;

    localparam int SW = $clog2(WIDTH);

    alu_state_t       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] zhi_q, zhi_d;
    logic [WIDTH-1:0] zlo_q, zlo_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             div_q;

    logic             accept_s;
    logic             mc_s;
    logic [SW-1:0]    amt_s;
    logic [2*WIDTH-1:0] dbl_s;
    logic [WIDTH-1:0] ror_s, rol_s;
    logic [WIDTH-1:0] sc_res_s;
    logic             sc_err_s;
    logic             eng_load_s, eng_step_s, eng_last_s, eng_err_s;
    logic [WIDTH-1:0] eng_hi_s, eng_lo_s;

    assign accept_s = bus.start & ~busy_q;
    assign mc_s     = is_multicycle(bus.operation);
    assign amt_s    = bus.B[SW-1:0];
    // Rotates as shifts of A concatenated with itself: amount 0 falls out naturally.
    assign dbl_s    = {bus.A, bus.A};
    assign ror_s    = WIDTH'(dbl_s >> amt_s);
    assign rol_s    = WIDTH'((dbl_s << amt_s) >> WIDTH);

    // Single-cycle result mux; anything not decoded here is illegal
    always_comb begin
        sc_res_s = {WIDTH{1'b0}};
        sc_err_s = 1'b0;
        case (bus.operation)
            OP_ADD:  sc_res_s = bus.A + bus.B;
            OP_SUB:  sc_res_s = bus.A - bus.B;
            OP_SHR:  sc_res_s = bus.A >> amt_s;
            OP_SHRA: sc_res_s = $signed(bus.A) >>> amt_s;
            OP_SHL:  sc_res_s = bus.A << amt_s;
            OP_ROR:  sc_res_s = ror_s;
            OP_ROL:  sc_res_s = rol_s;
            OP_AND:  sc_res_s = bus.A & bus.B;
            OP_OR:   sc_res_s = bus.A | bus.B;
            OP_NEG:  sc_res_s = {WIDTH{1'b0}} - bus.A;
            OP_NOT:  sc_res_s = ~bus.A;
            default: sc_err_s = 1'b1;
        endcase
    end

    // Handshake FSM; FIX is the done cycle of a multi-cycle op and accepts like IDLE
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        zhi_d      = zhi_q;
        zlo_d      = zlo_q;
        eng_load_s = 1'b0;
        eng_step_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_FIX: begin
                if (accept_s && mc_s) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                end else if (accept_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    zlo_d   = sc_res_s;
                    zhi_d   = {WIDTH{1'b0}};
                    err_d   = sc_err_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                eng_load_s = 1'b1;
                state_d    = ST_ITER;
            end
            ST_ITER: begin
                eng_step_s = 1'b1;
                if (eng_last_s) begin
                    state_d = ST_FIX;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    zhi_d   = eng_hi_s;
                    zlo_d   = eng_lo_s;
                    err_d   = eng_err_s;
                end else begin
                    state_d = ST_ITER;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            zhi_q   <= {WIDTH{1'b0}};
            zlo_q   <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
        end
    end

    // Operand capture on accept only
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q   <= {WIDTH{1'b0}};
            b_q   <= {WIDTH{1'b0}};
            div_q <= 1'b0;
        end else if (accept_s) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            div_q <= (bus.operation == OP_DIV);
        end
    end

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clock  (clock),
        .reset  (reset),
        .load_i (eng_load_s),
        .step_i (eng_step_s),
        .div_i  (div_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .last_o (eng_last_s),
        .hi_o   (eng_hi_s),
        .lo_o   (eng_lo_s),
        .err_o  (eng_err_s)
    );

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.zhi  = zhi_q;
    assign bus.zlo  = zlo_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 and WIDTH=8.
module tb_seq_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) bus32();
    seq_alu_if #(.WIDTH(8))  bus8();

    seq_alu #(.WIDTH(32)) dut32 (.clock(clk), .reset(rst), .bus(bus32.slave));
    seq_alu #(.WIDTH(8))  dut8  (.clock(clk), .reset(rst), .bus(bus8.slave));

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_lo;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one multi-cycle op on the 32-bit DUT, poke an ignored start at N+5,
    // and check latency, busy, result and hold.
    task automatic run_mc(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic eerr);
        int cyc;
        bit got;
        bit busy_ok;
        bus32.start = 1'b1; bus32.operation = op; bus32.A = a; bus32.B = b;
        tick();
        bus32.start = 1'b0; bus32.operation = OP_ADD; bus32.A = ~a; bus32.B = 32'h0000_0000;
        cyc = 1; got = 1'b0; busy_ok = 1'b1;
        while (!got && cyc < 40) begin
            if (bus32.done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (bus32.busy !== 1'b1) busy_ok = 1'b0;
                bus32.start = (cyc == 5);
                tick();
                cyc++;
            end
        end
        bus32.start = 1'b0;
        chk({name, " done seen"}, 64'(got), 64'd1);
        chk({name, " latency"}, 64'(cyc), 64'd34);
        chk({name, " busy during op"}, 64'(busy_ok), 64'd1);
        chk({name, " busy at done"}, 64'(bus32.busy), 64'd0);
        chk({name, " zhi:zlo"}, {bus32.zhi, bus32.zlo}, {ehi, elo});
        chk({name, " err"}, 64'(bus32.err), 64'(eerr));
        tick();
        chk({name, " done one cycle"}, 64'(bus32.done), 64'd0);
        chk({name, " zlo hold"}, 64'(bus32.zlo), 64'(elo));
    endtask

    task automatic run_mc8(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] eprod);
        int cyc;
        bit got;
        bus8.start = 1'b1; bus8.operation = OP_MUL; bus8.A = a; bus8.B = b;
        tick();
        bus8.start = 1'b0; bus8.A = 8'h00; bus8.B = 8'h00;
        cyc = 1; got = 1'b0;
        while (!got && cyc < 20) begin
            if (bus8.done === 1'b1) begin
                got = 1'b1;
            end else begin
                tick();
                cyc++;
            end
        end
        chk({name, " latency"}, 64'(cyc), 64'd10);
        chk({name, " zhi:zlo"}, 64'({bus8.zhi, bus8.zlo}), 64'(eprod));
        chk({name, " err"}, 64'(bus8.err), 64'd0);
    endtask

    initial begin
        bus32.start = 1'b0; bus32.operation = 5'b00000; bus32.A = 32'h0; bus32.B = 32'h0;
        bus8.start  = 1'b0; bus8.operation  = 5'b00000; bus8.A  = 8'h00;  bus8.B  = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        chk("reset busy", 64'(bus32.busy), 64'd0);
        chk("reset done", 64'(bus32.done), 64'd0);
        chk("reset err",  64'(bus32.err),  64'd0);
        chk("reset zhi:zlo", {bus32.zhi, bus32.zlo}, 64'd0);
        chk("reset w8 busy/done", 64'({bus8.busy, bus8.done}), 64'd0);
        rst = 1'b0;

        vecs.push_back(vec_t'{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0});
        vecs.push_back(vec_t'{OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back(vec_t'{OP_SHRA, 32'h8000_0010, 32'h0000_0104, 32'hF800_0001, 1'b0});
        vecs.push_back(vec_t'{OP_ROL,  32'h8000_0001, 32'h0000_0001, 32'h0000_0003, 1'b0});
        vecs.push_back(vec_t'{OP_SHR,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0});
        vecs.push_back(vec_t'{OP_SHL,  32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1'b0});
        vecs.push_back(vec_t'{OP_SHL,  32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 1'b0});
        vecs.push_back(vec_t'{OP_ROR,  32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 1'b0});
        vecs.push_back(vec_t'{OP_ROR,  32'h1234_5678, 32'hFFFF_FF00, 32'h1234_5678, 1'b0});
        vecs.push_back(vec_t'{OP_ROL,  32'h1234_5678, 32'h0000_0004, 32'h2345_6781, 1'b0});
        vecs.push_back(vec_t'{OP_SHRA, 32'h4000_0000, 32'h0000_001E, 32'h0000_0001, 1'b0});
        vecs.push_back(vec_t'{OP_SHRA, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back(vec_t'{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0});
        vecs.push_back(vec_t'{OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0});
        vecs.push_back(vec_t'{OP_NEG,  32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back(vec_t'{OP_NEG,  32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0});
        vecs.push_back(vec_t'{OP_NOT,  32'h0000_FFFF, 32'h0000_0000, 32'hFFFF_0000, 1'b0});
        vecs.push_back(vec_t'{5'b11111, 32'h0000_1234, 32'h0000_0005, 32'h0000_0000, 1'b1});
        vecs.push_back(vec_t'{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0});
        vecs.push_back(vec_t'{5'b00000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1});
`ifndef ALU_DIV_EN
        vecs.push_back(vec_t'{OP_DIV,  32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1});
`endif

        // Each vector is issued in the done cycle of the previous one.
        for (int i = 0; i < vecs.size(); i++) begin
            bus32.start = 1'b1;
            bus32.operation = vecs[i].op;
            bus32.A = vecs[i].a;
            bus32.B = vecs[i].b;
            tick();
            chk($sformatf("vec%0d done", i), 64'(bus32.done), 64'd1);
            chk($sformatf("vec%0d busy", i), 64'(bus32.busy), 64'd0);
            chk($sformatf("vec%0d zlo", i),  64'(bus32.zlo),  64'(vecs[i].exp_lo));
            chk($sformatf("vec%0d zhi", i),  64'(bus32.zhi),  64'd0);
            chk($sformatf("vec%0d err", i),  64'(bus32.err),  64'(vecs[i].exp_err));
        end
        bus32.start = 1'b0;
        bus32.A = 32'hDEAD_BEEF;
        tick();
        chk("idle no done", 64'(bus32.done), 64'd0);
        chk("idle err hold", 64'(bus32.err), 64'(vecs[vecs.size()-1].exp_err));

        run_mc("mul -3*7", OP_MUL, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_mc("mul min*min", OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_mc("mul -1*-1", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
`ifdef ALU_DIV_EN
        run_mc("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_mc("div 7/-2", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_mc("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_mc("div 5/0", OP_DIV, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
`endif
        run_mc("mul max*max", OP_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0);

        run_mc8("w8 mul 80*80", 8'h80, 8'h80, 16'h4000);
        run_mc8("w8 mul -3*7",  8'hFD, 8'h07, 16'hFFEB);

        // Reset in cycle N+10 of a MUL aborts it without a done pulse.
        begin
            bit seen;
            bus32.start = 1'b1; bus32.operation = OP_MUL; bus32.A = 32'h0000_0003; bus32.B = 32'h0000_0005;
            tick();
            bus32.start = 1'b0;
            for (int k = 1; k < 10; k++) tick();
            rst = 1'b1;
            tick();
            chk("abort busy", 64'(bus32.busy), 64'd0);
            chk("abort done", 64'(bus32.done), 64'd0);
            chk("abort err",  64'(bus32.err),  64'd0);
            chk("abort zhi:zlo", {bus32.zhi, bus32.zlo}, 64'd0);
            rst = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (bus32.done === 1'b1) seen = 1'b1;
                tick();
            end
            chk("abort no done", 64'(seen), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
